// File: rtl/fc5_ctrl.sv
// fc5_ctrl: weight-ROM / feature-buffer sequencer for the C5/F5 fully-connected layer.
// Define FC5_CTRL_BIAS_EN to add a trailing bias beat at ROM address N_IN.
module fc5_ctrl #(
  parameter int unsigned N_IN    = 400,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] w5_raddr,
  output logic [ADDR_W-1:0] in_raddr,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              acc_bias,
  output logic              res_valid,
  input  logic              res_ready
);

`ifdef FC5_CTRL_BIAS_EN
  localparam int unsigned N_BEATS = N_IN + 1;
  localparam bit          BIAS_EN = 1'b1;
`else
  localparam int unsigned N_BEATS = N_IN;
  localparam bit          BIAS_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_BEATS - 1);
  localparam logic [ADDR_W-1:0] IN_MAX   = ADDR_W'(N_IN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   cnt_d;
  logic [ADDR_W-1:0]   in_d;
  logic                busy_d;
  logic                res_valid_d;
  logic                at_last;
  logic                beat_v;
  logic                beat_first;
  logic                beat_last;
  logic                beat_bias;
  logic [ROM_LAT-1:0]  pipe_v;
  logic [ROM_LAT-1:0]  pipe_first;
  logic [ROM_LAT-1:0]  pipe_last;
  logic [ROM_LAT-1:0]  pipe_bias;

  // w5_raddr doubles as the beat counter
  assign at_last = (w5_raddr == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (at_last)   state_d = DRAIN;
      DRAIN:   if (acc_last)  state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and the beat entering the latency pipe
  always_comb begin
    cnt_d      = w5_raddr;
    beat_v     = 1'b0;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    beat_bias  = 1'b0;
    if (state == RUN) begin
      beat_v     = 1'b1;
      beat_first = (w5_raddr == '0);
      beat_last  = at_last;
      beat_bias  = BIAS_EN && at_last;
      if (!at_last) cnt_d = w5_raddr + ADDR_W'(1);
    end
    if (state_d == IDLE) cnt_d = '0;
    // the bias beat re-reads the last feature word while the ROM serves the bias
    in_d        = (cnt_d > IN_MAX) ? IN_MAX : cnt_d;
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      w5_raddr   <= '0;
      in_raddr   <= '0;
      pipe_v     <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
      pipe_bias  <= '0;
    end else begin
      busy       <= busy_d;
      res_valid  <= res_valid_d;
      w5_raddr   <= cnt_d;
      in_raddr   <= in_d;
      pipe_v     <= ROM_LAT'({pipe_v, beat_v});
      pipe_first <= ROM_LAT'({pipe_first, beat_first});
      pipe_last  <= ROM_LAT'({pipe_last, beat_last});
      pipe_bias  <= ROM_LAT'({pipe_bias, beat_bias});
    end
  end

  assign acc_en   = pipe_v[ROM_LAT-1];
  assign acc_clr  = pipe_first[ROM_LAT-1];
  assign acc_last = pipe_last[ROM_LAT-1];
  assign acc_bias = pipe_bias[ROM_LAT-1];

endmodule

// File: tb/tb_fc5_ctrl.sv
// Bench for fc5_ctrl: random passes with backpressure and mid-pass reset, checked by a
// timeline reference model feeding a scoreboard; a second small instance covers ROM_LAT=2.
`timescale 1ns/1ps
module tb_fc5_ctrl;
  localparam int unsigned N_IN    = 400;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned ROM_LAT = 1;
  localparam int unsigned N_IN2   = 4;
  localparam int unsigned LAT2    = 2;
`ifdef FC5_CTRL_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  localparam int NB  = int'(N_IN) + int'(BIAS);
  localparam int NB2 = int'(N_IN2) + int'(BIAS);

  typedef struct { int cyc; bit clr; bit last; bit bias; } beat_t;

  logic clk = 1'b0;
  logic rst, start, res_ready, start2;
  logic busy, acc_en, acc_clr, acc_last, acc_bias, res_valid;
  logic [ADDR_W-1:0] w5_raddr, in_raddr;
  logic busy2, acc_en2, acc_clr2, acc_last2, acc_bias2, res_valid2;
  logic [ADDR_W-1:0] w5_raddr2, in_raddr2;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;
  bit  rv_prev = 1'b0;
  bit  m_busy = 1'b0;
  int  m_t0 = 0;
  int  m_hs_min = 0;
  beat_t beat_q[$];
  int  rise_q[$];
  int  fall_q[$];
  beat_t log2_q[$];
  int  rv2_q[$];

  fc5_ctrl #(.N_IN(N_IN), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .w5_raddr(w5_raddr), .in_raddr(in_raddr),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_last(acc_last), .acc_bias(acc_bias),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  fc5_ctrl #(.N_IN(N_IN2), .ADDR_W(ADDR_W), .ROM_LAT(LAT2)) dut_small (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2),
    .w5_raddr(w5_raddr2), .in_raddr(in_raddr2),
    .acc_en(acc_en2), .acc_clr(acc_clr2), .acc_last(acc_last2), .acc_bias(acc_bias2),
    .res_valid(res_valid2), .res_ready(1'b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a pass accepted at edge t0 puts beat k on the accumulators after
  // edge t0+k+ROM_LAT, raises the result after t0+NB+ROM_LAT, and ends on the handshake.
  always @(posedge clk or posedge rst) begin : model
    int    e;
    beat_t b;
    if (rst) begin
      m_busy = 1'b0;
      beat_q.delete();
      rise_q.delete();
      fall_q.delete();
    end else begin
      e = cyc + 1;
      if (!m_busy) begin
        if (start) begin
          m_busy   = 1'b1;
          m_t0     = e;
          m_hs_min = e + NB + int'(ROM_LAT) + 1;
          for (int k = 0; k < NB; k++) begin
            b.cyc  = e + k + int'(ROM_LAT);
            b.clr  = (k == 0);
            b.last = (k == NB - 1);
            b.bias = BIAS && (k == int'(N_IN));
            beat_q.push_back(b);
          end
          rise_q.push_back(e + NB + int'(ROM_LAT));
        end
      end else if (res_ready && e >= m_hs_min) begin
        m_busy = 1'b0;
        fall_q.push_back(e);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a result edge
  always @(negedge clk) begin : monitor
    beat_t b;
    int    ea;
    int    ei;
    if (rst || !mon_en) begin
      rv_prev = 1'b0;
    end else begin
      while (beat_q.size() > 0 && beat_q[0].cyc < cyc) begin
        check("beat_missing", 0, beat_q[0].cyc);
        void'(beat_q.pop_front());
      end
      if (acc_en) begin
        if (beat_q.size() == 0) check("acc_en_unexpected", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_cycle", cyc, b.cyc);
          check("acc_clr", int'(acc_clr), int'(b.clr));
          check("acc_last", int'(acc_last), int'(b.last));
          check("acc_bias", int'(acc_bias), int'(b.bias));
        end
      end else if (acc_clr || acc_last || acc_bias) begin
        check("strobe_without_en", int'({acc_clr, acc_last, acc_bias}), 0);
      end
      if (acc_en && res_valid) check("acc_en_during_res_valid", 1, 0);
      if (res_valid && !rv_prev) begin
        if (rise_q.size() == 0) check("res_valid_unexpected", 1, 0);
        else check("res_valid_rise", cyc, rise_q.pop_front());
      end
      if (!res_valid && rv_prev) begin
        if (fall_q.size() == 0) check("res_valid_fall_unexpected", 1, 0);
        else check("res_valid_fall", cyc, fall_q.pop_front());
      end
      rv_prev = res_valid;
      if (m_busy) begin
        ea = cyc - m_t0;
        if (ea > NB - 1) ea = NB - 1;
      end else ea = 0;
      ei = (ea > int'(N_IN) - 1) ? int'(N_IN) - 1 : ea;
      check("busy", int'(busy), int'(m_busy));
      check("w5_raddr", int'(w5_raddr), ea);
      check("in_raddr", int'(in_raddr), ei);
    end
  end

  always @(negedge clk) begin : small_log
    beat_t b;
    if (!rst) begin
      if (acc_en2) begin
        b.cyc = cyc; b.clr = acc_clr2; b.last = acc_last2; b.bias = acc_bias2;
        log2_q.push_back(b);
      end
      if (res_valid2) rv2_q.push_back(cyc);
    end
  end

  task automatic check_zero();
    check("rst_busy", int'(busy), 0);
    check("rst_w5_raddr", int'(w5_raddr), 0);
    check("rst_in_raddr", int'(in_raddr), 0);
    check("rst_acc_en", int'(acc_en), 0);
    check("rst_acc_clr", int'(acc_clr), 0);
    check("rst_acc_last", int'(acc_last), 0);
    check("rst_acc_bias", int'(acc_bias), 0);
    check("rst_res_valid", int'(res_valid), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || m_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_rv(input bit poke);
    int n = 0;
    while (!res_valid && n < 3000) begin
      start = poke && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 3000) check("res_valid_timeout", int'(res_valid), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t2;
    rst = 1'b0; start = 1'b0; res_ready = 1'b0; start2 = 1'b0;
    // asynchronous reset in the middle of a low phase
    #12 rst = 1'b1;
    #1 check_zero();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // nominal pass, result accepted at once
    res_ready = 1'b1;
    pulse_start();
    wait_idle();
    repeat (2) @(negedge clk);

    // backpressure: result held 50 cycles, stray start in HOLD ignored
    res_ready = 1'b0;
    pulse_start();
    wait_rv(1'b0);
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_res_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_idle();
    repeat (3) @(negedge clk);

    // reset in the middle of a pass, then a full pass
    pulse_start();
    repeat (198) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    wait_idle();

    // random passes: random ready delay and stray starts while busy
    for (int p = 0; p < 4; p++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      res_ready = 1'b0;
      pulse_start();
      wait_rv(1'b1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      res_ready = 1'b1;
      wait_idle();
    end

    // small instance: ROM_LAT=2, N_IN=4
    @(negedge clk);
    t2 = cyc + 1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (NB2 + int'(LAT2) + 6) @(negedge clk);
    check("small_beat_count", int'(log2_q.size()), NB2);
    for (int i = 0; i < int'(log2_q.size()) && i < NB2; i++) begin
      check("small_en_cycle", log2_q[i].cyc, t2 + int'(LAT2) + i);
      check("small_clr", int'(log2_q[i].clr), int'(i == 0));
      check("small_last", int'(log2_q[i].last), int'(i == NB2 - 1));
    end
    check("small_rv_count", int'(rv2_q.size()), 1);
    if (rv2_q.size() > 0) check("small_rv_cycle", rv2_q[0], t2 + NB2 + int'(LAT2));
    check("small_busy_end", int'(busy2), 0);

    check("beats_left", int'(beat_q.size()), 0);
    check("rises_left", int'(rise_q.size()), 0);
    check("falls_left", int'(fall_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
